// File: rtl/uart_mem_loader_pkg.sv
// Shared constants, FSM state type and address helper for the UART memory loader.
package uart_mem_loader_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        RESP = 3'd5
    } state_t;

    // Byte address of a word: base plus the zero-extended index times four, no wrap check.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// UART byte link plus data-memory write port, seen from the loader (master) and its surroundings (slave).
interface uart_mem_loader_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        tx_done;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;

    modport master (
        input  rx_byte, rx_valid, tx_done,
        output tx_byte, tx_valid, mem_wr, mem_addr, mem_wr_data
    );

    modport slave (
        output rx_byte, rx_valid, tx_done,
        input  tx_byte, tx_valid, mem_wr, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/uart_mem_loader_timeout.sv
// Inter-byte idle counter: cleared by every received byte, saturates at LIMIT and flags expiry while enabled.
module uart_mem_loader_timeout #(
    parameter int unsigned LIMIT = 78130
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // Idle-cycle counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst || clr) begin
            count <= '0;
        end else if (en && count != W'(LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == W'(LIMIT));
endmodule

// File: rtl/uart_mem_loader.sv
// Host frame parser: A5 | LEN_LO | LEN_HI | LEN x 4 data bytes | XOR checksum.
// Writes assembled little-endian words to consecutive addresses and answers ACK or NAK.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MAX_WORDS    = 512,
    parameter int unsigned TIMEOUT_CLKS = 78130
) (
    input  logic              clk,
    input  logic              rst,
    uart_mem_loader_if.master bus,
    output logic              cpu_hold,
    output logic              load_done
);
    state_t      state, state_n;
    logic [15:0] len, len_n;
    logic [7:0]  csum, csum_n;
    logic [31:0] word, word_n;
    logic [1:0]  byte_idx, byte_idx_n;
    logic [15:0] word_idx, word_idx_n;
    logic        mem_wr_q, mem_wr_n;
    logic [7:0]  resp_byte, resp_n;
    logic        load_done_q, load_done_n;
    logic [15:0] len_rx;
    logic        timer_en;
    logic        expire;

    assign len_rx   = {bus.rx_byte, len[7:0]};
    assign timer_en = state inside {LEN0, LEN1, DATA, CSUM};

    uart_mem_loader_timeout #(.LIMIT(TIMEOUT_CLKS)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.rx_valid),
        .en     (timer_en),
        .expire (expire)
    );

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            len         <= '0;
            csum        <= '0;
            word        <= '0;
            byte_idx    <= '0;
            word_idx    <= '0;
            mem_wr_q    <= 1'b0;
            resp_byte   <= '0;
            load_done_q <= 1'b0;
        end else begin
            state       <= state_n;
            len         <= len_n;
            csum        <= csum_n;
            word        <= word_n;
            byte_idx    <= byte_idx_n;
            word_idx    <= word_idx_n;
            mem_wr_q    <= mem_wr_n;
            resp_byte   <= resp_n;
            load_done_q <= load_done_n;
        end
    end

    // Next-state, word assembly, checksum and response selection.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n     = state;
        len_n       = len;
        csum_n      = csum;
        word_n      = word;
        byte_idx_n  = byte_idx;
        word_idx_n  = word_idx;
        mem_wr_n    = 1'b0;
        resp_n      = resp_byte;
        load_done_n = 1'b0;

        // The write strobe cycle has presented this word's address; move to the next one.
        if (mem_wr_q) begin
            word_idx_n = word_idx + 16'd1;
        end

        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_byte == HDR_BYTE) begin
                    state_n = LEN0;
                    csum_n  = '0;
                end
            end
            LEN0: begin
                if (bus.rx_valid) begin
                    len_n[7:0] = bus.rx_byte;
                    csum_n     = csum ^ bus.rx_byte;
                    state_n    = LEN1;
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = NAK_BYTE;
                end
            end
            LEN1: begin
                if (bus.rx_valid) begin
                    len_n      = len_rx;
                    csum_n     = csum ^ bus.rx_byte;
                    word_idx_n = '0;
                    byte_idx_n = '0;
                    if (len_rx == '0 || len_rx > 16'(MAX_WORDS)) begin
                        state_n = RESP;
                        resp_n  = NAK_BYTE;
                    end else begin
                        state_n = DATA;
                    end
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = NAK_BYTE;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    word_n[{byte_idx, 3'b000} +: 8] = bus.rx_byte;
                    csum_n     = csum ^ bus.rx_byte;
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem_wr_n = 1'b1;
                        if (word_idx == len - 16'd1) begin
                            state_n = CSUM;
                        end
                    end
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = NAK_BYTE;
                end
            end
            CSUM: begin
                if (bus.rx_valid) begin
                    state_n = RESP;
                    if (csum == bus.rx_byte) begin
                        resp_n      = ACK_BYTE;
                        load_done_n = 1'b1;
                    end else begin
                        resp_n = NAK_BYTE;
                    end
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = NAK_BYTE;
                end
            end
            RESP: begin
                if (bus.tx_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.tx_byte     = resp_byte;
    assign bus.tx_valid    = (state == RESP);
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = word_addr(BASE_ADDR, word_idx);
    assign bus.mem_wr_data = word;
    assign cpu_hold        = (state != IDLE);
    assign load_done       = load_done_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: directed frames plus randomized frames scored
// against a frame-level model (expected writes and response derived from the byte stream rules).
module tb_uart_mem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 512;
    localparam int          TO   = 60;
    localparam logic [7:0]  HDR  = 8'hA5;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic clk;
    logic rst;
    logic cpu_hold;
    logic load_done;

    uart_mem_loader_if bus();

    uart_mem_loader #(
        .BASE_ADDR    (BASE),
        .MAX_WORDS    (MAXW),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .load_done (load_done)
    );

    int tests  = 0;
    int failed = 0;
    int ld_cnt = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the write port and the load_done pulse once per cycle.
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            got_addr.push_back(bus.mem_addr);
            got_data.push_back(bus.mem_wr_data);
        end
        if (load_done === 1'b1) ld_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        ld_cnt = 0;
    endtask

    // Called on a negedge: one-cycle rx strobe, then gap idle cycles; returns on a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) send_byte(frame_q[i], (gap < 0) ? int'($urandom_range(4, 0)) : gap);
    endtask

    // Frame-level model: valid length -> every word written at BASE+4*i; ACK only if checksum good.
    task automatic build_frame(input int len, input bit corrupt, output logic [7:0] exp_resp, output int exp_ld);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  lo;
        logic [7:0]  hi;
        lo = 8'(len);
        hi = 8'(len >> 8);
        frame_q.delete();
        exp_addr.delete();
        exp_data.delete();
        frame_q.push_back(HDR);
        frame_q.push_back(lo);
        frame_q.push_back(hi);
        sum = lo ^ hi;
        if (len >= 1 && len <= MAXW) begin
            for (int i = 0; i < len; i++) begin
                w = $urandom;
                if ($urandom_range(3, 0) == 0) w[15:8] = HDR;
                for (int b = 0; b < 4; b++) begin
                    frame_q.push_back(w[8*b +: 8]);
                    sum = sum ^ w[8*b +: 8];
                end
                exp_addr.push_back(BASE + 32'(i) * 32'd4);
                exp_data.push_back(w);
            end
            frame_q.push_back(corrupt ? (sum ^ 8'(1 << $urandom_range(7, 0))) : sum);
            exp_resp = corrupt ? NAK : ACK;
            exp_ld   = corrupt ? 0 : 1;
        end else begin
            exp_resp = NAK;
            exp_ld   = 0;
        end
    endtask

    task automatic check_writes(input string name);
        tests++;
        if (got_addr.size() != exp_addr.size()) begin
            failed++;
            $display("FAIL %s writes: got %0d writes, expected %0d", name, got_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                tests++;
                if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                    failed++;
                    $display("FAIL %s write %0d: got %h@%h, expected %h@%h",
                             name, i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
                end
            end
        end
    endtask

    // Wait for the response, hold it (optionally with rx noise), release with tx_done, then score writes.
    task automatic check_response(input string name, input logic [7:0] exp_byte, input int exp_ld, input bit junk);
        int n = 0;
        while (bus.tx_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.tx_valid !== 1'b1) begin
            failed++;
            $display("FAIL %s resp: tx_valid not seen within %0d cycles", name, n);
            return;
        end
        tests++;
        if (bus.tx_byte !== exp_byte) begin
            failed++;
            $display("FAIL %s tx_byte: got %h, expected %h", name, bus.tx_byte, exp_byte);
        end
        tests++;
        if (cpu_hold !== 1'b1) begin
            failed++;
            $display("FAIL %s cpu_hold in resp: got %b, expected 1", name, cpu_hold);
        end
        for (int i = 0; i < 4; i++) begin
            if (junk) begin
                bus.rx_byte  = (i == 0) ? HDR : 8'($urandom);
                bus.rx_valid = 1'b1;
            end
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        tests++;
        if (bus.tx_valid !== 1'b1 || bus.tx_byte !== exp_byte) begin
            failed++;
            $display("FAIL %s hold: got valid %b byte %h, expected 1 %h", name, bus.tx_valid, bus.tx_byte, exp_byte);
        end
        tests++;
        if (ld_cnt != exp_ld) begin
            failed++;
            $display("FAIL %s load_done: got %0d pulse cycles, expected %0d", name, ld_cnt, exp_ld);
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        tests++;
        if (bus.tx_valid !== 1'b0 || cpu_hold !== 1'b0) begin
            failed++;
            $display("FAIL %s release: got tx_valid %b cpu_hold %b, expected 0 0", name, bus.tx_valid, cpu_hold);
        end
        check_writes(name);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.tx_valid, bus.tx_byte, bus.mem_wr, bus.mem_addr, bus.mem_wr_data, cpu_hold, load_done} !== '0) begin
            failed++;
            $display("FAIL reset outputs: got tv=%b tb=%h wr=%b a=%h d=%h h=%b ld=%b, expected all 0",
                     bus.tx_valid, bus.tx_byte, bus.mem_wr, bus.mem_addr, bus.mem_wr_data, cpu_hold, load_done);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        clear_obs();
        frame_q  = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        exp_addr = '{32'h0000_0000};
        exp_data = '{32'h4433_2211};
        send_frame(2);
        check_response("single_word", ACK, 1, 1'b0);
    endtask

    task automatic test_bad_csum();
        clear_obs();
        frame_q  = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        exp_addr = '{32'h0000_0000, 32'h0000_0004};
        exp_data = '{32'h4433_2211, 32'h8877_6655};
        send_frame(1);
        check_response("bad_csum", NAK, 0, 1'b0);
    endtask

    task automatic test_bad_len();
        logic [7:0] r;
        int         l;
        clear_obs();
        frame_q = '{8'hA5, 8'h00, 8'h00};
        exp_addr.delete();
        exp_data.delete();
        send_frame(1);
        check_response("len_zero", NAK, 0, 1'b0);
        clear_obs();
        frame_q = '{8'hA5, 8'h01, 8'h02};
        send_frame(1);
        check_response("len_513", NAK, 0, 1'b0);
        clear_obs();
        build_frame(MAXW, 1'b0, r, l);
        send_frame(0);
        check_response("len_max", r, l, 1'b0);
    endtask

    task automatic test_timeout();
        clear_obs();
        exp_addr.delete();
        exp_data.delete();
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h00, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, TO);
        tests++;
        if (bus.tx_valid !== 1'b0) begin
            failed++;
            $display("FAIL timeout early: got tx_valid %b before expiry, expected 0", bus.tx_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.tx_valid !== 1'b1) begin
            failed++;
            $display("FAIL timeout edge: got tx_valid %b after expiry, expected 1", bus.tx_valid);
        end
        check_response("timeout", NAK, 0, 1'b0);

        clear_obs();
        exp_addr = '{32'h0000_0000};
        exp_data = '{32'h4433_2211};
        send_byte(8'hA5, 2);
        send_byte(8'h01, 2);
        send_byte(8'h00, 2);
        send_byte(8'h11, 2);
        send_byte(8'h22, TO);
        send_byte(8'h33, 2);
        send_byte(8'h44, 2);
        send_byte(8'h45, 2);
        check_response("expiry_byte", ACK, 1, 1'b0);
    endtask

    task automatic test_ignore();
        logic [7:0] r;
        int         l;
        logic [7:0] idle_bytes[3];
        idle_bytes = '{8'h00, 8'hFF, 8'h5A};
        clear_obs();
        foreach (idle_bytes[i]) begin
            send_byte(idle_bytes[i], 1);
            tests++;
            if (cpu_hold !== 1'b0 || bus.tx_valid !== 1'b0) begin
                failed++;
                $display("FAIL idle byte %h: got cpu_hold %b tx_valid %b, expected 0 0",
                         idle_bytes[i], cpu_hold, bus.tx_valid);
            end
        end
        tests++;
        if (got_addr.size() != 0) begin
            failed++;
            $display("FAIL idle writes: got %0d, expected 0", got_addr.size());
        end
        clear_obs();
        build_frame(2, 1'b0, r, l);
        send_frame(-1);
        check_response("resp_noise", r, l, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] r;
        int         l;
        clear_obs();
        build_frame(3, 1'b0, r, l);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i], 1);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.tx_valid, bus.tx_byte, bus.mem_wr, bus.mem_addr, bus.mem_wr_data, cpu_hold, load_done} !== '0) begin
            failed++;
            $display("FAIL mid reset outputs: got tv=%b tb=%h wr=%b a=%h d=%h h=%b ld=%b, expected all 0",
                     bus.tx_valid, bus.tx_byte, bus.mem_wr, bus.mem_addr, bus.mem_wr_data, cpu_hold, load_done);
        end
        rst = 1'b1;
        repeat (TO + 10) @(negedge clk);
        tests++;
        if (bus.tx_valid !== 1'b0 || cpu_hold !== 1'b0 || got_addr.size() != 1) begin
            failed++;
            $display("FAIL mid reset abandon: got tx_valid %b cpu_hold %b writes %0d, expected 0 0 1",
                     bus.tx_valid, cpu_hold, got_addr.size());
        end
        clear_obs();
        build_frame(3, 1'b0, r, l);
        send_frame(-1);
        check_response("after_reset", r, l, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] r;
        int         l;
        for (int k = 0; k < 15; k++) begin
            clear_obs();
            build_frame(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0), r, l);
            send_frame(-1);
            check_response($sformatf("random_%0d", k), r, l, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_done  = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_bad_csum();
        test_bad_len();
        test_timeout();
        test_ignore();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
